// File: rtl/bus_initiator.sv
// Single-outstanding femto bus initiator: one command in, one bus request out, one response pulse back.
// Optional fault reporting to the reset controller is enabled with `define BUS_INITIATOR_FAULT_REPORT_EN.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module bus_initiator #(
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [7:0]  CAUSE_BUSFLT = 8'h10,
    parameter logic [7:0]  CAUSE_TMO    = 8'h11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [`XLEN-1:0]          cmd_addr,
    input  logic                      cmd_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] cmd_acc,
    input  logic [`BUS_WIDTH-1:0]     cmd_wdata,
    output logic                      rsp_valid,
    output logic [`BUS_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_err,
    output logic [`XLEN-1:0]          addr,
    output logic                      w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [`BUS_WIDTH-1:0]     wdata,
    output logic                      req,
    input  logic [`BUS_WIDTH-1:0]     rdata,
    input  logic                      resp,
    input  logic                      fault,
    output logic                      soc_fault,
    output logic [7:0]                soc_fault_cause,
    output logic [`XLEN-1:0]          soc_fault_addr
);

    localparam int unsigned XW = `XLEN;
    localparam int unsigned DW = `BUS_WIDTH;
    localparam int unsigned AW = `BUS_ACC_WIDTH;
    localparam int unsigned CW = 8;

    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);
    localparam logic [1:0]    ERR_OK    = 2'b00;
    localparam logic [1:0]    ERR_BUS   = 2'b01;
    localparam logic [1:0]    ERR_TMO   = 2'b10;
    localparam logic [1:0]    ERR_MIS   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [XW-1:0]   addr_n;
    logic            w_rb_n;
    logic [AW-1:0]   acc_n;
    logic [DW-1:0]   wdata_n;
    logic [DW-1:0]   rsp_rdata_n;
    logic [1:0]      rsp_err_n;
    logic            req_n;
    logic            rsp_valid_n;
    logic            cmd_ready_n;
    logic            misaligned;

    assign misaligned = ((cmd_acc == `BUS_ACC_2B) && cmd_addr[0]) ||
                        ((cmd_acc == `BUS_ACC_4B) && (cmd_addr[1:0] != 2'b00));

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        addr_n      = addr;
        w_rb_n      = w_rb;
        acc_n       = acc;
        wdata_n     = wdata;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        req_n       = 1'b0;
        rsp_valid_n = 1'b0;
        cmd_ready_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_n  = cmd_addr;
                    w_rb_n  = cmd_w_rb;
                    acc_n   = cmd_acc;
                    wdata_n = cmd_wdata;
                    if (misaligned) begin
                        rsp_err_n = ERR_MIS;
                        state_n   = S_RSP;
                    end else begin
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (fault) begin
                    rsp_err_n = ERR_BUS;
                    state_n   = S_RSP;
                end else begin
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_n = CW'(cnt + 1'b1);
                // A completion in the final WAIT cycle still counts as success
                if (resp) begin
                    if (!w_rb) begin
                        rsp_rdata_n = rdata;
                    end
                    rsp_err_n = ERR_OK;
                    state_n   = S_RSP;
                end else if (cnt_n == TMO_LIMIT) begin
                    rsp_err_n = ERR_TMO;
                    state_n   = S_RSP;
                end
            end
            S_RSP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        req_n       = (state_n == S_REQ);
        rsp_valid_n = (state_n == S_RSP);
        cmd_ready_n = (state_n == S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr      <= '0;
            w_rb      <= 1'b0;
            acc       <= `BUS_ACC_1B;
            wdata     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            req       <= 1'b0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            addr      <= addr_n;
            w_rb      <= w_rb_n;
            acc       <= acc_n;
            wdata     <= wdata_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            req       <= req_n;
            rsp_valid <= rsp_valid_n;
            cmd_ready <= cmd_ready_n;
        end
    end

`ifdef BUS_INITIATOR_FAULT_REPORT_EN
    logic report;

    assign report = (state_n == S_RSP) && ((rsp_err_n == ERR_BUS) || (rsp_err_n == ERR_TMO));

    // Fault report pulses alongside rsp_valid; cause and address persist until the next report
    always_ff @(posedge clk) begin
        if (rst) begin
            soc_fault       <= 1'b0;
            soc_fault_cause <= '0;
            soc_fault_addr  <= '0;
        end else begin
            soc_fault <= report;
            if (report) begin
                soc_fault_cause <= (rsp_err_n == ERR_BUS) ? CAUSE_BUSFLT : CAUSE_TMO;
                soc_fault_addr  <= addr;
            end
        end
    end
`else
    logic unused_cause;

    assign unused_cause    = ^{CAUSE_BUSFLT, CAUSE_TMO};
    assign soc_fault       = 1'b0;
    assign soc_fault_cause = '0;
    assign soc_fault_addr  = '0;
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Testbench for bus_initiator: randomized commands and responder behaviour checked against a
// transaction-level model of latency, status, read data and fault reporting.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_bus_initiator;

    localparam int TMO = 16;
    localparam int XW  = `XLEN;
    localparam int DW  = `BUS_WIDTH;
    localparam int AW  = `BUS_ACC_WIDTH;

    localparam int M_RESP  = 0;
    localparam int M_FAULT = 1;
    localparam int M_NONE  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [XW-1:0] cmd_addr;
    logic          cmd_w_rb;
    logic [AW-1:0] cmd_acc;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_err;
    logic [XW-1:0] addr;
    logic          w_rb;
    logic [AW-1:0] acc;
    logic [DW-1:0] wdata;
    logic          req;
    logic [DW-1:0] rdata;
    logic          resp;
    logic          fault;
    logic          soc_fault;
    logic [7:0]    soc_fault_cause;
    logic [XW-1:0] soc_fault_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state that persists across transactions
    logic [DW-1:0] m_rdata;
    logic [7:0]    m_cause;
    logic [XW-1:0] m_faddr;

    always #5 clk = ~clk;

    bus_initiator #(
        .TIMEOUT      (TMO),
        .CAUSE_BUSFLT (8'h10),
        .CAUSE_TMO    (8'h11)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_w_rb        (cmd_w_rb),
        .cmd_acc         (cmd_acc),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .addr            (addr),
        .w_rb            (w_rb),
        .acc             (acc),
        .wdata           (wdata),
        .req             (req),
        .rdata           (rdata),
        .resp            (resp),
        .fault           (fault),
        .soc_fault       (soc_fault),
        .soc_fault_cause (soc_fault_cause),
        .soc_fault_addr  (soc_fault_addr)
    );

    function automatic int acc_bytes(input logic [AW-1:0] a);
        if (a == `BUS_ACC_1B) return 1;
        if (a == `BUS_ACC_2B) return 2;
        return 4;
    endfunction

    // One command plus responder behaviour, compared against the expected transaction outcome
    task automatic do_access(input string tag, input logic [XW-1:0] a, input logic w,
                             input logic [AW-1:0] s, input logic [DW-1:0] wd,
                             input int mode, input int d, input logic [DW-1:0] rd);
        int            req_cnt;
        int            req_k;
        int            rsp_cnt;
        int            rsp_k;
        int            soc_cnt;
        int            exp_req;
        int            exp_rsp_k;
        logic [1:0]    exp_err;
        logic          exp_soc;
        logic [XW-1:0] b_addr;
        logic          b_w;
        logic [AW-1:0] b_acc;
        logic [DW-1:0] b_wd;
        logic [1:0]    o_err;
        logic [DW-1:0] o_rdata;
        logic          o_soc;
        logic [7:0]    o_cause;
        logic [XW-1:0] o_faddr;
        logic          done;
        req_cnt = 0; req_k = -1; rsp_cnt = 0; rsp_k = -1; soc_cnt = 0; done = 1'b0;
        b_addr = '0; b_w = 1'b0; b_acc = '0; b_wd = '0;
        o_err = '0; o_rdata = '0; o_soc = 1'b0; o_cause = '0; o_faddr = '0;

        if ((int'(a[1:0]) % acc_bytes(s)) != 0) begin
            exp_req = 0; exp_rsp_k = 1; exp_err = 2'b11;
        end else if (mode == M_FAULT) begin
            exp_req = 1; exp_rsp_k = 2; exp_err = 2'b01;
        end else if (mode == M_RESP && d <= TMO) begin
            exp_req = 1; exp_rsp_k = 2 + d; exp_err = 2'b00;
        end else begin
            exp_req = 1; exp_rsp_k = 2 + TMO; exp_err = 2'b10;
        end
        exp_soc = (exp_err == 2'b01) || (exp_err == 2'b10);

        for (int k = 0; k < TMO + 8 && !done; k++) begin
            if (req) begin
                req_cnt++; req_k = k;
                b_addr = addr; b_w = w_rb; b_acc = acc; b_wd = wdata;
            end
            if (rsp_valid) begin
                rsp_cnt++; rsp_k = k;
                o_err = rsp_err; o_rdata = rsp_rdata;
                o_soc = soc_fault; o_cause = soc_fault_cause; o_faddr = soc_fault_addr;
            end
            if (soc_fault) soc_cnt++;

            if (rsp_k >= 0 && k == rsp_k + 1) begin
                n_cmp++;
                if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || addr !== a) begin
                    n_bad++;
                    $display("FAIL %s post: cmd_ready=%b rsp_valid=%b addr=%h, required 1 0 %h",
                             tag, cmd_ready, rsp_valid, addr, a);
                end
                resp = 1'b0; fault = 1'b0; cmd_valid = 1'b0;
                done = 1'b1;
            end else begin
                if (k == 0) begin
                    n_cmp++;
                    if (cmd_ready !== 1'b1) begin
                        n_bad++;
                        $display("FAIL %s ready: cmd_ready=%b, required 1", tag, cmd_ready);
                    end
                    cmd_valid = 1'b1; cmd_addr = a; cmd_w_rb = w; cmd_acc = s; cmd_wdata = wd;
                end else begin
                    // Commands presented while busy must be ignored
                    cmd_valid = (rsp_cnt == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    cmd_addr  = $urandom; cmd_w_rb = 1'($urandom);
                    cmd_acc   = AW'($urandom_range(0, 2)); cmd_wdata = $urandom;
                end
                fault = (mode == M_FAULT) && req;
                resp  = (mode == M_RESP) && (req_k >= 0) && (k == req_k + d);
                rdata = resp ? rd : $urandom;
                if (rsp_valid) begin
                    resp  = 1'($urandom);
                    fault = 1'($urandom);
                end
                @(posedge clk);
                @(negedge clk);
            end
        end

        if (exp_err == 2'b00 && !w) m_rdata = rd;
`ifdef BUS_INITIATOR_FAULT_REPORT_EN
        if (exp_soc) begin
            m_cause = (exp_err == 2'b01) ? 8'h10 : 8'h11;
            m_faddr = a;
        end
`else
        exp_soc = 1'b0;
`endif

        n_cmp++;
        if (req_cnt != exp_req) begin
            n_bad++;
            $display("FAIL %s req_count: got %0d, required %0d", tag, req_cnt, exp_req);
        end
        if (exp_req == 1) begin
            n_cmp++;
            if (req_k != 1 || b_addr !== a || b_w !== w || b_acc !== s || b_wd !== wd) begin
                n_bad++;
                $display("FAIL %s bus: cyc=%0d addr=%h w=%b acc=%0d wd=%h, required 1 %h %b %0d %h",
                         tag, req_k, b_addr, b_w, b_acc, b_wd, a, w, s, wd);
            end
        end
        n_cmp++;
        if (rsp_cnt != 1 || rsp_k != exp_rsp_k) begin
            n_bad++;
            $display("FAIL %s rsp_timing: count=%0d cyc=%0d, required 1 %0d",
                     tag, rsp_cnt, rsp_k, exp_rsp_k);
        end
        n_cmp++;
        if (o_err !== exp_err || o_rdata !== m_rdata) begin
            n_bad++;
            $display("FAIL %s rsp_data: err=%b rdata=%h, required %b %h",
                     tag, o_err, o_rdata, exp_err, m_rdata);
        end
        n_cmp++;
        if (soc_cnt != int'(exp_soc) || o_soc !== exp_soc ||
            o_cause !== m_cause || o_faddr !== m_faddr) begin
            n_bad++;
            $display("FAIL %s soc: pulses=%0d at_rsp=%b cause=%h addr=%h, required %0d %b %h %h",
                     tag, soc_cnt, o_soc, o_cause, o_faddr, exp_soc, exp_soc, m_cause, m_faddr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_w_rb = 1'b0; cmd_acc = '0;
        cmd_wdata = '0; rdata = '0; resp = 1'b0; fault = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0; m_cause = '0; m_faddr = '0;
        n_cmp++;
        if (cmd_ready !== 1'b1 || req !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 2'b00 ||
            rsp_rdata !== '0 || addr !== '0 || w_rb !== 1'b0 || acc !== `BUS_ACC_1B ||
            wdata !== '0 || soc_fault !== 1'b0 || soc_fault_cause !== 8'h00 ||
            soc_fault_addr !== '0) begin
            n_bad++;
            $display("FAIL reset: ready=%b req=%b rv=%b err=%b rd=%h addr=%h w=%b acc=%0d wd=%h soc=%b/%h/%h",
                     cmd_ready, req, rsp_valid, rsp_err, rsp_rdata, addr, w_rb, acc, wdata,
                     soc_fault, soc_fault_cause, soc_fault_addr);
        end
    endtask

    task automatic test_directed();
        do_access("read4_ok",    32'h4, 1'b0, `BUS_ACC_4B, 32'h0,    M_RESP,  1,   32'hDEADBEEF);
        do_access("write2_flt",  32'h0, 1'b1, `BUS_ACC_2B, 32'h0001, M_FAULT, 0,   32'h0);
        do_access("read2_tmo",   32'h8, 1'b0, `BUS_ACC_2B, 32'h0,    M_NONE,  0,   32'h0);
        do_access("read4_mis",   32'h6, 1'b0, `BUS_ACC_4B, 32'h0,    M_RESP,  1,   32'h12345678);
        do_access("read2_mis",   32'h3, 1'b0, `BUS_ACC_2B, 32'h0,    M_RESP,  1,   32'h0);
        do_access("read1_odd",   32'h3, 1'b0, `BUS_ACC_1B, 32'h0,    M_RESP,  2,   32'h000000A5);
        do_access("resp_last",   32'hC, 1'b0, `BUS_ACC_4B, 32'h0,    M_RESP,  TMO, 32'hCAFEF00D);
        do_access("resp_late",   32'h10, 1'b0, `BUS_ACC_4B, 32'h0,   M_RESP,  TMO + 1, 32'h0BADF00D);
        do_access("write_ok",    32'h20, 1'b1, `BUS_ACC_4B, 32'h55AA55AA, M_RESP, 3, 32'hFFFFFFFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int            mode;
            int            d;
            logic [AW-1:0] s;
            logic [XW-1:0] a;
            mode = $urandom_range(0, 9);
            mode = (mode < 6) ? M_RESP : ((mode < 8) ? M_FAULT : M_NONE);
            d    = $urandom_range(1, TMO + 2);
            s    = AW'($urandom_range(0, 2));
            a    = $urandom;
            do_access("random", a, 1'($urandom), s, $urandom, mode, d, $urandom);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [XW-1:0] a;
            a = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            do_access("b2b", a, 1'(i % 2), `BUS_ACC_4B, $urandom, M_RESP, 1, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        int rv_seen;
        rv_seen = 0;
        cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_w_rb = 1'b0; cmd_acc = `BUS_ACC_4B;
        cmd_wdata = '0;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid req: req=%b, required 1", req);
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b1; resp = 1'b1; rdata = 32'h99999999;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; resp = 1'b0;
        m_rdata = '0; m_cause = '0; m_faddr = '0;
        n_cmp++;
        if (cmd_ready !== 1'b1 || req !== 1'b0 || rsp_valid !== 1'b0 || soc_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid state: ready=%b req=%b rv=%b soc=%b, required 1 0 0 0",
                     cmd_ready, req, rsp_valid, soc_fault);
        end
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid || soc_fault) rv_seen++;
            @(posedge clk); @(negedge clk);
        end
        n_cmp++;
        if (rv_seen != 0) begin
            n_bad++;
            $display("FAIL rst_mid dropped: late pulses=%0d, required 0", rv_seen);
        end
        do_access("after_rst", 32'h44, 1'b0, `BUS_ACC_4B, 32'h0, M_RESP, 2, 32'h600DCAFE);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
